// File: rtl/dpram_sc.sv
// Single-clock simple dual-port RAM: one write port, one read port.
// Read path is combinational by default so a FIFO can fall through from dq.
module dpram_sc #(
   parameter int aw      = 3,
   parameter int dw      = 16,
   parameter bit REG_OUT = 1'b0
) (
   input  logic          ck,
   input  logic          rst,
   input  logic          rd,
   input  logic [aw-1:0] ra,
   output logic [dw-1:0] dq,
   input  logic          wr,
   input  logic [aw-1:0] wa,
   input  logic [dw-1:0] di
);

   localparam int depth = 1 << aw;

   logic [dw-1:0] mem [depth];

   // Reset clears every word and wins over a same-cycle write.
   always_ff @(posedge ck) begin
      if (rst) begin
         for (int i = 0; i < depth; i++)
            mem[i] <= '0;
      end else if (wr) begin
         mem[wa] <= di;
      end
   end

   generate
      if (REG_OUT) begin : g_reg
         logic [dw-1:0] q;

         // Samples pre-edge contents, so same-address access is read-before-write.
         always_ff @(posedge ck) begin
            if (rst)
               q <= '0;
            else if (rd)
               q <= mem[ra];
         end

         assign dq = q;
      end else begin : g_comb
         assign dq = rd ? mem[ra] : '0;
      end
   endgenerate

endmodule

// File: tb/tb_dpram_sc.sv
// Scoreboard bench for dpram_sc: one combinational and one
// registered instance share the same stimulus.
module tb_dpram_sc;

   logic        ck;
   logic        rst;
   logic        rd;
   logic [2:0]  ra;
   logic        wr;
   logic [2:0]  wa;
   logic [15:0] di;
   logic [15:0] dq0;
   logic [15:0] dq1;

   int total = 0;
   int bad   = 0;

   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   dpram_sc #(.aw(3), .dw(16), .REG_OUT(1'b0)) u_comb (
      .ck(ck), .rst(rst), .rd(rd), .ra(ra), .dq(dq0),
      .wr(wr), .wa(wa), .di(di)
   );

   dpram_sc #(.aw(3), .dw(16), .REG_OUT(1'b1)) u_reg (
      .ck(ck), .rst(rst), .rd(rd), .ra(ra), .dq(dq1),
      .wr(wr), .wa(wa), .di(di)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   task automatic chk(input string tag,
                      input logic [15:0] got,
                      input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic pop0(input string tag);
      if (q0.size() == 0)
         chk({tag, " (empty q0)"}, 16'hxxxx, 16'h0000);
      else
         chk(tag, dq0, q0.pop_front());
   endtask

   task automatic pop1(input string tag);
      if (q1.size() == 0)
         chk({tag, " (empty q1)"}, 16'hxxxx, 16'h0000);
      else
         chk(tag, dq1, q1.pop_front());
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      rd  = 1'b1;
      ra  = '0;
      wr  = 1'b0;
      wa  = '0;
      di  = '0;

      tick();
      tick();
      @(negedge ck);
      rst = 1'b0;
      q1.push_back(16'h0000);
      pop1("rst_reg");
      for (int i = 0; i < 8; i++) begin
         ra = 3'(i);
         q0.push_back(16'h0000);
         #1;
         pop0($sformatf("rst_rd%0d", i));
      end

      // fill 1..8 then sweep without clocking
      @(negedge ck);
      wr = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wa = 3'(i);
         di = 16'(i + 1);
         tick();
      end
      wr = 1'b0;
      @(negedge ck);
      for (int i = 0; i < 8; i++) begin
         ra = 3'(i);
         q0.push_back(16'(i + 1));
         #1;
         pop0($sformatf("fill_rd%0d", i));
      end

      // same-address read/write, no bypass
      @(negedge ck);
      wr = 1'b1;
      wa = 3'd3;
      ra = 3'd3;
      di = 16'hABCD;
      q0.push_back(16'h0004);
      #1;
      pop0("rw_old");
      q0.push_back(16'hABCD);
      q1.push_back(16'h0004);
      tick();
      pop0("rw_new");
      pop1("rw_reg_old");
      wr = 1'b0;
      q1.push_back(16'hABCD);
      tick();
      pop1("rw_reg_new");

      // wrap 7 -> 0
      @(negedge ck);
      wr = 1'b1;
      wa = 3'd7;
      di = 16'h1111;
      tick();
      wa = 3'd0;
      di = 16'h2222;
      tick();
      wr = 1'b0;
      ra = 3'd7;
      q0.push_back(16'h1111);
      #1;
      pop0("wrap7");
      ra = 3'd0;
      q0.push_back(16'h2222);
      #1;
      pop0("wrap0");
      q1.push_back(16'h2222);
      tick();
      pop1("wrap0_reg");

      // rd = 0: comb output zero, register holds
      @(negedge ck);
      ra = 3'd7;
      q1.push_back(16'h1111);
      tick();
      pop1("hold_load");
      rd = 1'b0;
      q0.push_back(16'h0000);
      #1;
      pop0("rd0_comb");
      wr = 1'b1;
      wa = 3'd7;
      di = 16'h7777;
      q1.push_back(16'h1111);
      tick();
      pop1("hold1");
      q1.push_back(16'h1111);
      tick();
      pop1("hold2");
      wr = 1'b0;
      rd = 1'b1;
      q0.push_back(16'h7777);
      #1;
      pop0("rd1_comb");

      // reset during a write
      @(negedge ck);
      rst = 1'b1;
      wr  = 1'b1;
      wa  = 3'd2;
      di  = 16'h5555;
      tick();
      rst = 1'b0;
      wr  = 1'b0;
      q1.push_back(16'h0000);
      pop1("rst_wr_reg");
      for (int i = 0; i < 8; i++) begin
         ra = 3'(i);
         q0.push_back(16'h0000);
         #1;
         pop0($sformatf("rst_wr_rd%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
